// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the HD44780-style bus responder.
package lcd_pkg;

    localparam int         DDRAM_DEPTH = 128;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    // Opcode match patterns; each mask also covers the zero bits above the opcode bit.
    localparam logic [7:0] OP_SET_DDRAM_MASK = 8'h80;
    localparam logic [7:0] OP_SET_DDRAM_VAL  = 8'h80;
    localparam logic [7:0] OP_FUNC_SET_MASK  = 8'hE0;
    localparam logic [7:0] OP_FUNC_SET_VAL   = 8'h20;
    localparam logic [7:0] OP_ENTRY_MASK     = 8'hFC;
    localparam logic [7:0] OP_ENTRY_VAL      = 8'h04;
    localparam logic [7:0] OP_HOME_MASK      = 8'hFE;
    localparam logic [7:0] OP_HOME_VAL       = 8'h02;
    localparam logic [7:0] OP_CLEAR_MASK     = 8'hFF;
    localparam logic [7:0] OP_CLEAR_VAL      = 8'h01;
    localparam int         FUNC_DL_BIT       = 4;
    localparam int         ENTRY_ID_BIT      = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_e;

    typedef enum logic [2:0] {
        INS_NOP,
        INS_SET_DDRAM,
        INS_FUNC_SET,
        INS_ENTRY,
        INS_HOME,
        INS_CLEAR
    } lcd_instr_e;

    function automatic lcd_instr_e decode_instr(input logic [7:0] b);
        if ((b & OP_SET_DDRAM_MASK) == OP_SET_DDRAM_VAL)     return INS_SET_DDRAM;
        else if ((b & OP_FUNC_SET_MASK) == OP_FUNC_SET_VAL)  return INS_FUNC_SET;
        else if ((b & OP_ENTRY_MASK) == OP_ENTRY_VAL)        return INS_ENTRY;
        else if ((b & OP_HOME_MASK) == OP_HOME_VAL)          return INS_HOME;
        else if ((b & OP_CLEAR_MASK) == OP_CLEAR_VAL)        return INS_CLEAR;
        else                                                 return INS_NOP;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic id);
        return id ? a + 7'd1 : a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_sync2.sv
// Two-flop synchronizer for asynchronous bus inputs; clears to 0 on reset.
module lcd_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780 bus-side responder: decodes uC strobes, keeps DDRAM/AC and models busy time.
// Optional 4-bit (nibble) transfers are enabled by defining LCD_RESP_NIBBLE_EN.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 2000,
    parameter int BUSY_LONG   = 76000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       data_valid,
    output logic [7:0] data_byte,
    output logic       busy,
    output logic [6:0] ac,
    output logic       err_overrun,
    output lcd_state_e o_dbg_state
);

    localparam int CNT_MAX = (BUSY_LONG > BUSY_CYCLES) ? BUSY_LONG : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    if (BUSY_LONG < 130) begin : g_busy_long_check
        $error("BUSY_LONG must be at least 130");
    end

    logic       w_rs;
    logic       w_rw;
    logic       w_en;
    logic [7:0] w_db;

    lcd_sync2 #(.W(1)) u_sync_rs (.clk(clk), .rst(rst), .i_d(rs),    .o_q(w_rs));
    lcd_sync2 #(.W(1)) u_sync_rw (.clk(clk), .rst(rst), .i_d(rw),    .o_q(w_rw));
    lcd_sync2 #(.W(1)) u_sync_en (.clk(clk), .rst(rst), .i_d(en),    .o_q(w_en));
    lcd_sync2 #(.W(8)) u_sync_db (.clk(clk), .rst(rst), .i_d(db_in), .o_q(w_db));

    lcd_state_e       r_state;
    lcd_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [6:0]       r_fill;
    logic [6:0]       w_fill_nxt;
    logic             r_en_d;
    logic [6:0]       r_ac;
    logic             r_id;
    logic             r_cmd_valid;
    logic [7:0]       r_cmd_byte;
    logic             r_data_valid;
    logic [7:0]       r_data_byte;
    logic             r_err;
    logic [7:0]       r_ddram [DDRAM_DEPTH];

    logic       w_strobe;
    logic       w_xfer;
    logic [7:0] w_byte;
    logic       w_nib_mode;
    logic       w_nib_phase;
    logic       w_ready;
    logic       w_wr;
    logic       w_cmd_acc;
    logic       w_dat_acc;
    logic       w_rd_step;
    lcd_instr_e w_instr;
    logic [7:0] w_rd_byte;

    assign w_strobe = r_en_d & ~w_en;

`ifdef LCD_RESP_NIBBLE_EN
    logic       r_nib_mode;
    logic       r_nib_phase;
    logic [3:0] r_nib_hi;

    // Phase toggles on every strobe in 4-bit mode; any function set realigns it to the high nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nib_mode  <= 1'b0;
            r_nib_phase <= 1'b0;
            r_nib_hi    <= 4'h0;
        end else begin
            if (w_strobe && r_nib_mode) begin
                r_nib_phase <= ~r_nib_phase;
                if (!r_nib_phase) r_nib_hi <= w_db[7:4];
            end
            if (w_cmd_acc && w_instr == INS_FUNC_SET) begin
                r_nib_mode  <= ~w_byte[FUNC_DL_BIT];
                r_nib_phase <= 1'b0;
            end
        end
    end

    assign w_nib_mode  = r_nib_mode;
    assign w_nib_phase = r_nib_phase;
    assign w_xfer      = w_strobe & (~r_nib_mode | r_nib_phase);
    assign w_byte      = r_nib_mode ? {r_nib_hi, w_db[7:4]} : w_db;
`else
    assign w_nib_mode  = 1'b0;
    assign w_nib_phase = 1'b0;
    assign w_xfer      = w_strobe;
    assign w_byte      = w_db;
`endif

    // The last EXEC cycle counts as not busy so a strobe landing on busy's fall is accepted.
    assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_EXEC && r_cnt == '0);
    assign w_wr      = w_xfer & ~w_rw;
    assign w_cmd_acc = w_wr & w_ready & ~w_rs;
    assign w_dat_acc = w_wr & w_ready & w_rs;
    assign w_rd_step = w_xfer & w_rw & w_rs;
    assign w_instr   = decode_instr(w_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fill  <= 7'd0;
            r_en_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fill  <= w_fill_nxt;
            r_en_d  <= w_en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        case (r_state)
            ST_CLEAR: begin
                // The fill consumes 128 of the long busy cycles; EXEC covers the remainder.
                if (r_fill == 7'h7F) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = CNT_W'(BUSY_LONG - 129);
                end else begin
                    w_fill_nxt = r_fill + 7'd1;
                end
            end
            ST_IDLE, ST_EXEC: begin
                if (r_state == ST_EXEC) begin
                    if (r_cnt == '0) w_state_nxt = ST_IDLE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
                if (w_cmd_acc && w_instr == INS_CLEAR) begin
                    w_state_nxt = ST_CLEAR;
                    w_fill_nxt  = 7'd0;
                end else if (w_cmd_acc && w_instr == INS_HOME) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = CNT_W'(BUSY_LONG - 1);
                end else if (w_cmd_acc || w_dat_acc) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = CNT_W'(BUSY_CYCLES - 1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac         <= 7'd0;
            r_id         <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_byte   <= 8'h00;
            r_data_valid <= 1'b0;
            r_data_byte  <= 8'h00;
            r_err        <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_data_valid <= 1'b0;
            r_err        <= w_wr & ~w_ready;
            if (w_cmd_acc) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= w_byte;
                case (w_instr)
                    INS_SET_DDRAM: r_ac <= w_byte[6:0];
                    INS_ENTRY:     r_id <= w_byte[ENTRY_ID_BIT];
                    INS_HOME:      r_ac <= 7'd0;
                    INS_CLEAR: begin
                        r_ac <= 7'd0;
                        r_id <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_dat_acc) begin
                r_data_valid <= 1'b1;
                r_data_byte  <= w_byte;
                r_ac         <= ac_step(r_ac, r_id);
            end else if (w_rd_step) begin
                r_ac <= ac_step(r_ac, r_id);
            end
        end
    end

    // DDRAM keeps its contents across reset; an interrupted fill simply stops.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)
            r_ddram[r_fill] <= BLANK_CHAR;
        else if (w_dat_acc)
            r_ddram[r_ac] <= w_byte;
    end

    always_comb begin
        w_rd_byte = w_rs ? r_ddram[r_ac] : {busy, r_ac};
        db_oe     = w_en & w_rw;
        db_out    = 8'h00;
        if (db_oe) begin
            if (w_nib_mode)
                db_out = w_nib_phase ? {w_rd_byte[3:0], 4'h0} : {w_rd_byte[7:4], 4'h0};
            else
                db_out = w_rd_byte;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign ac          = r_ac;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_byte    = r_cmd_byte;
    assign data_valid  = r_data_valid;
    assign data_byte   = r_data_byte;
    assign err_overrun = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder against a behavioural DDRAM/AC model.
module tb_lcd_bus_responder;
    import lcd_pkg::*;

    localparam int BUSY_CYCLES = 20;
    localparam int BUSY_LONG   = 200;
    localparam int WAIT_MAX    = BUSY_LONG + 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic [7:0] db_out, cmd_byte, data_byte;
    logic       db_oe, cmd_valid, data_valid, busy, err_overrun;
    logic [6:0] ac;
    lcd_state_e dbg_state;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY_CYCLES), .BUSY_LONG(BUSY_LONG)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rw(rw), .en(en), .db_in(db_in),
        .db_out(db_out), .db_oe(db_oe), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .data_valid(data_valid), .data_byte(data_byte), .busy(busy), .ac(ac),
        .err_overrun(err_overrun), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed pulses and busy-window bookkeeping, sampled away from the active edge.
    logic [7:0] cmd_q[$];
    logic [7:0] data_q[$];
    int err_cnt = 0, align_bad = 0, busy_run = 0, last_run = 0;
    logic prev_busy = 1'b0, prev_cmd = 1'b0, prev_dat = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid) cmd_q.push_back(cmd_byte);
        if (data_valid) data_q.push_back(data_byte);
        if (err_overrun) err_cnt++;
        if ((cmd_valid || data_valid) && !(busy && !prev_busy)) align_bad++;
        if ((cmd_valid && prev_cmd) || (data_valid && prev_dat)) align_bad++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        prev_busy = busy;
        prev_cmd  = cmd_valid;
        prev_dat  = data_valid;
    end

    // Reference model: display RAM, address counter, increment flag.
    logic [7:0] m_ram [128];
    int         m_ac = 0;
    logic       m_id = 1'b1;

    function automatic void m_step();
        m_ac = m_id ? (m_ac + 1) % 128 : (m_ac + 127) % 128;
    endfunction

    function automatic int m_cmd(input logic [7:0] b);
        int v = int'(b);
        if (v >= 128) m_ac = v - 128;
        else if (v >= 8) ;
        else if (v >= 4) m_id = b[1];
        else if (v >= 2) begin
            m_ac = 0;
            return BUSY_LONG;
        end else if (v == 1) begin
            for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
            m_ac = 0;
            m_id = 1'b1;
            return BUSY_LONG;
        end
        return BUSY_CYCLES;
    endfunction

    function automatic void m_data(input logic [7:0] b);
        m_ram[m_ac] = b;
        m_step();
    endfunction

    task automatic bus_write(input logic sel, input logic [7:0] b);
        @(negedge clk);
        rs = sel; rw = 1'b0; db_in = b; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic sel, output logic [7:0] d, output logic oe);
        @(negedge clk);
        rs = sel; rw = 1'b1; en = 1'b1;
        repeat (4) @(negedge clk);
        d = db_out; oe = db_oe;
        en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) begin
            n_checks++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({db_oe, db_out, busy, ac, cmd_valid, data_valid, cmd_byte, data_byte, err_overrun} !== '0)
            $display("FAIL reset_outputs: oe=%b out=%h busy=%b ac=%h cv=%b dv=%b cb=%h db=%h err=%b, required all 0",
                     db_oe, db_out, busy, ac, cmd_valid, data_valid, cmd_byte, data_byte, err_overrun);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_addr_data();
        logic [7:0] d; logic oe;
        cmd_q.delete(); data_q.delete(); align_bad = 0;
        void'(m_cmd(8'h85));
        bus_write(1'b0, 8'h85); wait_idle();
        n_checks++;
        if (cmd_q.size() != 1 || cmd_q[0] !== 8'h85) $display("FAIL addr_cmd_pulse: got %0d pulses first %h, required 1 x 85", cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (last_run != BUSY_CYCLES) $display("FAIL addr_busy_len: got %0d required %0d", last_run, BUSY_CYCLES);
        else n_pass++;
        m_data(8'h41);
        bus_write(1'b1, 8'h41); wait_idle();
        n_checks++;
        if (data_q.size() != 1 || data_q[0] !== 8'h41 || ac !== 7'(m_ac)) $display("FAIL data_write: pulses %0d ac %h, required 1 x 41 ac %h", data_q.size(), ac, 7'(m_ac));
        else n_pass++;
        n_checks++;
        if (last_run != BUSY_CYCLES) $display("FAIL data_busy_len: got %0d required %0d", last_run, BUSY_CYCLES);
        else n_pass++;
        void'(m_cmd(8'h85));
        bus_write(1'b0, 8'h85); wait_idle();
        bus_read(1'b1, d, oe); m_step();
        n_checks++;
        if (d !== m_ram[5] || oe !== 1'b1 || ac !== 7'(m_ac)) $display("FAIL ddram5_read: got %h oe %b ac %h, required %h oe 1 ac %h", d, oe, ac, m_ram[5], 7'(m_ac));
        else n_pass++;
        n_checks++;
        if (align_bad != 0) $display("FAIL pulse_align: got %0d misaligned pulses, required 0", align_bad);
        else n_pass++;
    endtask

    task automatic test_entry_dec();
        logic [7:0] d; logic oe;
        void'(m_cmd(8'h04)); bus_write(1'b0, 8'h04); wait_idle();
        void'(m_cmd(8'h80)); bus_write(1'b0, 8'h80); wait_idle();
        m_data(8'h42); bus_write(1'b1, 8'h42); wait_idle();
        n_checks++;
        if (ac !== 7'h7F) $display("FAIL entry_dec_wrap: ac %h required 7f", ac);
        else n_pass++;
        void'(m_cmd(8'h80)); bus_write(1'b0, 8'h80); wait_idle();
        bus_read(1'b1, d, oe); m_step();
        n_checks++;
        if (d !== 8'h42 || ac !== 7'h7F) $display("FAIL entry_dec_read: got %h ac %h, required 42 ac 7f", d, ac);
        else n_pass++;
        void'(m_cmd(8'h06)); bus_write(1'b0, 8'h06); wait_idle();
    endtask

    task automatic test_overrun();
        logic [7:0] d; logic oe;
        void'(m_cmd(8'h8A)); bus_write(1'b0, 8'h8A); wait_idle();
        m_data(8'h33); bus_write(1'b1, 8'h33); wait_idle();
        void'(m_cmd(8'h8A));
        data_q.delete(); err_cnt = 0;
        bus_write(1'b0, 8'h8A);
        bus_write(1'b1, 8'h55);
        wait_idle();
        n_checks++;
        if (err_cnt != 1 || data_q.size() != 0) $display("FAIL overrun_pulse: err pulses %0d data pulses %0d, required 1 and 0", err_cnt, data_q.size());
        else n_pass++;
        n_checks++;
        if (ac !== 7'd10) $display("FAIL overrun_ac: ac %h required 0a", ac);
        else n_pass++;
        bus_read(1'b1, d, oe); m_step();
        n_checks++;
        if (d !== 8'h33) $display("FAIL overrun_ram: got %h required 33", d);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [7:0] st, d; logic oe;
        int n, bad;
        cmd_q.delete();
        void'(m_cmd(8'h01));
        bus_write(1'b0, 8'h01);
        bus_read(1'b0, st, oe);
        n_checks++;
        if (st !== 8'h80 || oe !== 1'b1) $display("FAIL clear_status_busy: got %h oe %b, required 80 oe 1", st, oe);
        else n_pass++;
        n = 1;
        while (st[7] === 1'b1 && n < 100) begin
            bus_read(1'b0, st, oe);
            n++;
        end
        n_checks++;
        if (st !== 8'h00) $display("FAIL clear_status_done: got %h after %0d polls, required 00", st, n);
        else n_pass++;
        n_checks++;
        if (last_run != BUSY_LONG) $display("FAIL clear_busy_len: got %0d required %0d", last_run, BUSY_LONG);
        else n_pass++;
        n_checks++;
        if (cmd_q.size() != 1 || cmd_q[0] !== 8'h01) $display("FAIL clear_cmd_pulse: got %0d pulses, required 1 x 01", cmd_q.size());
        else n_pass++;
        void'(m_cmd(8'h80)); bus_write(1'b0, 8'h80); wait_idle();
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            bus_read(1'b1, d, oe);
            if (d !== m_ram[m_ac]) begin
                if (bad == 0) $display("FAIL clear_fill at %0d: got %h required %h", m_ac, d, m_ram[m_ac]);
                bad++;
            end
            m_step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL clear_fill_total: %0d bad locations, required 0", bad);
        else n_pass++;
        n_checks++;
        if (ac !== 7'(m_ac)) $display("FAIL clear_dump_ac: ac %h required %h", ac, 7'(m_ac));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b, d, exp; logic oe, sel;
        int op, exp_len;
        align_bad = 0;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 6);
            sel = 1'b0;
            b = 8'h00;
            case (op)
                0, 1: begin sel = 1'b1; b = 8'($urandom_range(0, 255)); end
                2: b = 8'h80 | 8'($urandom_range(0, 127));
                3: b = 8'h04 | 8'($urandom_range(0, 3));
                4: case ($urandom_range(0, 3))
                       0: b = 8'h08 + 8'($urandom_range(0, 23));
                       1: b = 8'h30 + 8'($urandom_range(0, 15));
                       2: b = 8'h40 + 8'($urandom_range(0, 63));
                       default: b = 8'h02 | 8'($urandom_range(0, 1));
                   endcase
                default: ;
            endcase
            if (op <= 4) begin
                cmd_q.delete(); data_q.delete();
                if (sel) begin m_data(b); exp_len = BUSY_CYCLES; end
                else exp_len = m_cmd(b);
                bus_write(sel, b); wait_idle();
                n_checks++;
                if (sel ? (data_q.size() != 1 || data_q[0] !== b || cmd_q.size() != 0)
                        : (cmd_q.size() != 1 || cmd_q[0] !== b || data_q.size() != 0))
                    $display("FAIL rnd_pulse[%0d]: rs %b cmd %0d data %0d pulses, required one of %h", k, sel, cmd_q.size(), data_q.size(), b);
                else n_pass++;
                n_checks++;
                if (last_run != exp_len) $display("FAIL rnd_busy_len[%0d]: got %0d required %0d", k, last_run, exp_len);
                else n_pass++;
            end else begin
                sel = (op == 5);
                exp = sel ? m_ram[m_ac] : {1'b0, 7'(m_ac)};
                bus_read(sel, d, oe);
                if (sel) m_step();
                n_checks++;
                if (d !== exp || oe !== 1'b1) $display("FAIL rnd_read[%0d]: rs %b got %h oe %b, required %h oe 1", k, sel, d, oe, exp);
                else n_pass++;
            end
            n_checks++;
            if (ac !== 7'(m_ac)) $display("FAIL rnd_ac[%0d]: got %h required %h", k, ac, 7'(m_ac));
            else n_pass++;
        end
        n_checks++;
        if (align_bad != 0) $display("FAIL rnd_pulse_align: %0d misaligned pulses, required 0", align_bad);
        else n_pass++;
    endtask

`ifdef LCD_RESP_NIBBLE_EN
    task automatic test_nibble();
        logic [7:0] d1, d2; logic oe;
        void'(m_cmd(8'h06)); bus_write(1'b0, 8'h06); wait_idle();
        bus_write(1'b0, 8'h20); wait_idle();
        bus_write(1'b0, 8'h90); bus_write(1'b0, 8'h00); wait_idle();
        void'(m_cmd(8'h90));
        data_q.delete();
        bus_write(1'b1, 8'h40);
        n_checks++;
        if (data_q.size() != 0 || busy !== 1'b0) $display("FAIL nib_first_half: data pulses %0d busy %b, required 0 and 0", data_q.size(), busy);
        else n_pass++;
        bus_write(1'b1, 8'h10); wait_idle();
        m_data(8'h41);
        n_checks++;
        if (data_q.size() != 1 || data_q[0] !== 8'h41 || ac !== 7'(m_ac)) $display("FAIL nib_data: pulses %0d ac %h, required 1 x 41 ac %h", data_q.size(), ac, 7'(m_ac));
        else n_pass++;
        bus_write(1'b0, 8'h90); bus_write(1'b0, 8'h00); wait_idle();
        void'(m_cmd(8'h90));
        bus_read(1'b1, d1, oe); bus_read(1'b1, d2, oe); m_step();
        n_checks++;
        if (d1 !== 8'h40 || d2 !== 8'h10 || ac !== 7'(m_ac)) $display("FAIL nib_read: got %h %h ac %h, required 40 10 ac %h", d1, d2, ac, 7'(m_ac));
        else n_pass++;
        bus_write(1'b0, 8'h30); bus_write(1'b0, 8'h00); wait_idle();
    endtask
`endif

    task automatic test_reset_mid_clear();
        void'(m_cmd(8'h01));
        bus_write(1'b0, 8'h01);
        repeat (40) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_CLEAR) $display("FAIL mid_clear_state: got %0d required %0d", dbg_state, ST_CLEAR);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({db_oe, db_out, busy, ac, cmd_valid, data_valid, cmd_byte, data_byte, err_overrun} !== '0 || dbg_state !== ST_IDLE)
            $display("FAIL mid_clear_reset: busy %b ac %h cb %h state %0d, required all 0 and idle", busy, ac, cmd_byte, dbg_state);
        else n_pass++;
        rst = 1'b0;
        m_ac = 0; m_id = 1'b1;
        repeat (3) @(negedge clk);
        void'(m_cmd(8'h85)); bus_write(1'b0, 8'h85); wait_idle();
        m_data(8'h41); bus_write(1'b1, 8'h41); wait_idle();
        n_checks++;
        if (ac !== 7'(m_ac)) $display("FAIL post_reset_write: ac %h required %h", ac, 7'(m_ac));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addr_data();
        test_entry_dec();
        test_overrun();
        test_clear();
        test_random();
`ifdef LCD_RESP_NIBBLE_EN
        test_nibble();
`endif
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000: clk cycles of busy after any accepted write except clear/home.
REQ-002 SHALL have parameter BUSY_LONG, default 76000: clk cycles of busy after clear/home; it SHALL be at least 130.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports rs, rw, en: inputs, 1 bit each, HD44780 bus controls driven by the uC.
REQ-006 SHALL have ports db_in (input, 8), db_out (output, 8) and db_oe (output, 1): the split data bus; the top level drives the pad when db_oe=1.
REQ-007 SHALL have ports cmd_valid (output, 1) and cmd_byte (output, 8): one-cycle pulse with each accepted instruction.
REQ-008 SHALL have ports data_valid (output, 1) and data_byte (output, 8): one-cycle pulse with each accepted data write.
REQ-009 SHALL have ports busy (output, 1), ac (output, 7) and err_overrun (output, 1): the busy flag, the address counter, and a one-cycle pulse when a write is dropped.

Function
REQ-010 SHALL pass rs, rw, en and db_in through 2-flop synchronizers; all edge decisions use the synced values.
REQ-011 SHALL treat a synced en falling edge as a strobe and sample rs, rw and db at that cycle.
REQ-012 SHALL handle a write strobe (rw=0) as follows: rs=0 is an instruction, rs=1 is data.
REQ-013 SHALL, for a write strobe while busy=1, discard the write, pulse err_overrun, and leave the state unchanged.
REQ-014 SHALL execute instructions by priority on the highest set bit:
  - 1xxxxxxx: ac<=b[6:0].
  - 000001 I S: id<=I (S is ignored).
  - 0000001x: return home, ac<=0, long busy.
  - 00000001: clear, fill DDRAM with 0x20, ac<=0, id<=1, long busy.
  - All others: accepted, short busy only.
REQ-015 SHALL, on a data write, set ddram[ac]<=byte, then set ac<=ac+1 if id=1 else ac-1, with 7-bit wrap (0x7F->0x00, 0x00->0x7F).
REQ-016 SHALL drive db_oe=1 while synced en=1 and rw=1, and db_out as follows:
  - rs=0: {busy, ac}.
  - rs=1: ddram[ac].
REQ-017 SHALL, on a read strobe with rs=1, step ac per id; a read strobe with rs=0 SHALL have no side effect; reads are allowed while busy.
REQ-018 SHALL assert cmd_valid/data_valid exactly 1 cycle after the strobe cycle, with the byte held until the next pulse.
REQ-019 SHALL implement a state machine IDLE -> EXEC (count down busy counter) -> IDLE, and IDLE -> CLEAR (write 128 DDRAM locations, 1 per cycle) -> EXEC; busy=1 in EXEC and CLEAR.
REQ-020 SHALL raise busy in the cycle after an accepted write and keep it for exactly BUSY_CYCLES (or BUSY_LONG) cycles, clear fill included.
REQ-021 SHALL give a strobe that coincides with busy falling the busy=0 treatment.

Reset
REQ-022 SHALL, on reset, set db_oe=0, db_out=0, busy=0, ac=0, id=1, cmd_valid=0, data_valid=0, cmd_byte=0, data_byte=0, err_overrun=0, state IDLE, and synchronizers to 0.
REQ-023 SHALL not reset DDRAM; a reset during CLEAR aborts the fill and leaves the contents undefined.

Configuration
REQ-024 SHALL, with LCD_RESP_NIBBLE_EN defined, behave as follows:
  - A function-set instruction (001x_xxxx) with b4=0 selects 4-bit mode; b4=1 selects 8-bit mode.
  - In 4-bit mode, each transfer is two strobes on db[7:4], high nibble first.
  - Reads return the high nibble, then the low nibble.
  - A nibble-phase flag toggles per strobe and resets to 0 on reset and on mode change.
  - ac steps only after the second nibble.
REQ-025 SHALL, without LCD_RESP_NIBBLE_EN, always operate in 8-bit mode and ignore b4.

Structure
REQ-026 SHALL place in shared package lcd_pkg:
  - The instruction opcode masks and constants.
  - The state enum (IDLE/EXEC/CLEAR).
  - The DDRAM depth (128).
  - The blank char 0x20.
REQ-027 SHALL use one sub-module, lcd_sync2, the 2-flop synchronizer, instantiated per control bit and for the db bus.

Verification
REQ-028 SHALL cover: write instruction 0x80|0x05, then data 0x41 -> cmd_valid with cmd_byte=0x85, ddram[5]=0x41, ac=0x06, busy high for BUSY_CYCLES.
REQ-029 SHALL cover: entry mode 0x04 (id=0) with ac=0, then data 0x42 -> ddram[0]=0x42, ac=0x7F.
REQ-030 SHALL cover: data write while busy=1 -> err_overrun pulses once, ddram and ac unchanged.
REQ-031 SHALL cover: clear 0x01, then poll status with rs=0, rw=1 -> db_out[7]=1 for BUSY_LONG cycles, then 0x00; all 128 locations read 0x20.
REQ-032 SHALL cover: rst asserted mid-CLEAR -> all outputs at reset values in the next cycle, state IDLE.
REQ-033 SHALL cover, with LCD_RESP_NIBBLE_EN: function set 0x20, then nibbles 0x4 and 0x1 with rs=1 -> single data_valid with data_byte=0x41.
